// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the E stage; owns the architectural HI/LO
// registers and raises busy while an operation is in flight.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        res_hi, res_lo;
  logic               res_we;
  logic [31:0]        res_hi_d, res_lo_d;
  logic               res_we_d;
  logic [CNT_W-1:0]   cnt_init;
  logic               launch, finish;

  assign launch = (state_q == IDLE) && start && (md_op inside {[OP_MULT:OP_DIVU]});
  assign finish = (state_q == RUN) && (cnt_q == '0);

  // Result is computed from the live operands at the launch edge and parked
  // until the final busy cycle; a zero divisor simply suppresses the write-back.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    res_hi_d = '0;
    res_lo_d = '0;
    res_we_d = 1'b1;
    cnt_init = CNT_W'(DIV_CYCLES - 1);
    unique case (md_op)
      OP_MULT: begin
        {res_hi_d, res_lo_d} = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        cnt_init = CNT_W'(MULT_CYCLES - 1);
      end
      OP_MULTU: begin
        {res_hi_d, res_lo_d} = {32'b0, A} * {32'b0, B};
        cnt_init = CNT_W'(MULT_CYCLES - 1);
      end
      OP_DIV: begin
        if (B == '0) begin
          res_we_d = 1'b0;
        end else begin
          // 33-bit signed divide keeps 0x80000000 / -1 from overflowing.
          res_lo_d = 32'($signed({A[31], A}) / $signed({B[31], B}));
          res_hi_d = 32'($signed({A[31], A}) % $signed({B[31], B}));
        end
      end
      OP_DIVU: begin
        if (B == '0) begin
          res_we_d = 1'b0;
        end else begin
          res_lo_d = A / B;
          res_hi_d = A % B;
        end
      end
      default: res_we_d = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the parked result is reset too, so an aborted op can never leak into HI/LO.
    if (!reset) begin
      cnt_q  <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_we <= 1'b0;
    end else if (launch) begin
      cnt_q  <= cnt_init;
      res_hi <= res_hi_d;
      res_lo <= res_lo_d;
      res_we <= res_we_d;
    end else if (state_q == RUN && cnt_q != '0) begin
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  // Architectural HI/LO: written by op completion or by MTHI/MTLO while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (finish) begin
      if (res_we) begin
        HI <= res_hi;
        LO <= res_lo;
      end
    end else if (state_q == IDLE && !start) begin
      if (md_op == OP_MTHI) HI <= A;
      if (md_op == OP_MTLO) LO <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: multiply/divide results, busy timing,
// divide-by-zero, ignored starts, MTHI/MTLO and asynchronous abort.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    check({tag, " busy"}, {31'b0, busy}, 32'd0);
    check({tag, " HI"}, HI, exp_hi);
    check({tag, " LO"}, LO, exp_lo);
  endtask

  // One in-flight cycle: busy must be high and HI/LO must hold their old values.
  task automatic run_cycle(input string tag, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
    check({tag, " busy"}, {31'b0, busy}, 32'd1);
    check({tag, " HI hold"}, HI, hold_hi);
    check({tag, " LO hold"}, LO, hold_lo);
    @(negedge clk);
  endtask

  task automatic run_cycles(input string tag, input int n,
                            input logic [31:0] hold_hi, input logic [31:0] hold_lo);
    for (int i = 0; i < n; i++) run_cycle(tag, hold_hi, hold_lo);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 3'd0; A = '0; B = '0;
    #12;
    idle_check("reset", 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Multiplies
    issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    run_cycles("mult", 5, 32'h0, 32'h0);
    idle_check("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_cycles("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    idle_check("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_cycles("mult_min", 5, 32'hFFFF_FFFE, 32'h0000_0001);
    idle_check("mult_min", 32'h4000_0000, 32'h0000_0000);

    // Divides
    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    run_cycles("div", 10, 32'h4000_0000, 32'h0000_0000);
    idle_check("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
    run_cycles("divu", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    idle_check("divu", 32'h0000_0001, 32'h7FFF_FFFC);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_cycles("div_ovf", 10, 32'h0000_0001, 32'h7FFF_FFFC);
    idle_check("div_ovf", 32'h0000_0000, 32'h8000_0000);

    // Starts with non-launching opcodes are ignored; start also blocks MTHI.
    @(negedge clk);
    start = 1'b1; md_op = 3'd7; A = 32'h1111_1111; B = 32'h2;
    @(negedge clk);
    idle_check("start_op7", 32'h0, 32'h8000_0000);
    md_op = 3'd5; A = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_check("start_op5", 32'h0, 32'h8000_0000);
    md_op = 3'd0;
    @(negedge clk);
    start = 1'b0;
    idle_check("start_op0", 32'h0, 32'h8000_0000);

    // MTHI, then divide by zero with illegal activity injected mid-run
    md_op = 3'd5; A = 32'h0000_1234;
    @(negedge clk);
    md_op = 3'd0;
    idle_check("mthi", 32'h0000_1234, 32'h8000_0000);

    issue(3'd3, 32'h0000_0055, 32'h0000_0000);
    run_cycles("div0", 3, 32'h0000_1234, 32'h8000_0000);
    start = 1'b1; md_op = 3'd1; A = 32'h2; B = 32'h3;
    run_cycle("div0_start", 32'h0000_1234, 32'h8000_0000);
    start = 1'b0; md_op = 3'd6; A = 32'h0000_CAFE;
    run_cycle("div0_mtlo", 32'h0000_1234, 32'h8000_0000);
    md_op = 3'd0;
    run_cycles("div0", 5, 32'h0000_1234, 32'h8000_0000);
    idle_check("div0_done", 32'h0000_1234, 32'h8000_0000);
    @(negedge clk);
    idle_check("div0_after", 32'h0000_1234, 32'h8000_0000);

    // Asynchronous abort mid-run
    issue(3'd3, 32'h0000_0064, 32'h0000_0007);
    run_cycles("abort_pre", 3, 32'h0000_1234, 32'h8000_0000);
    reset = 1'b0;
    #1;
    idle_check("abort", 32'h0, 32'h0);
    @(negedge clk);
    idle_check("abort_hold", 32'h0, 32'h0);
    reset = 1'b1;
    md_op = 3'd6; A = 32'h0000_0005;
    @(posedge clk);
    #1;
    idle_check("mtlo", 32'h0, 32'h0000_0005);
    md_op = 3'd0;

    issue(3'd2, 32'h0000_0007, 32'h0000_0006);
    run_cycles("multu_post", 5, 32'h0, 32'h0000_0005);
    idle_check("multu_post", 32'h0, 32'h0000_002A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
